// File: rtl/mem_if_pkg.sv
// Shared types and constants for the CPU data-memory initiator.
// Holds the access-size and FSM-state enums plus default address-map bases.
package mem_if_pkg;

    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2
    } mem_size_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [31:0] DEAD_BEEF     = 32'hDEAD_BEEF;
    localparam logic [31:0] DEF_DMEM_BASE = 32'h0000_6000;
    localparam logic [31:0] DEF_IO_BASE   = 32'h0001_0000;

    // Half needs bit 0 clear, word needs bits 1:0 clear.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lsb);
        return ((size == HALF) && lsb[0]) || ((size == WORD) && (lsb != 2'b00));
    endfunction

endpackage

// File: rtl/dmem_watchdog.sv
// Hang watchdog: counts enabled cycles and flags the last allowed one.
// Counter width is $clog2(TIMEOUT_CYC); clear has priority over enable.
module dmem_watchdog #(
    parameter int TIMEOUT_CYC = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int CW = $clog2(TIMEOUT_CYC);

    logic [CW-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    assign expire = enable && (count == CW'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/dmem_request_initiator.sv
// CPU-side initiator for the data-memory port: IDLE -> WAIT -> RESP per access.
// Build option: define MISALIGN_TRAP_EN to reject misaligned half/word accesses.
module dmem_request_initiator
    import mem_if_pkg::*;
#(
    parameter logic [31:0] DMEM_BASE   = DEF_DMEM_BASE,
    parameter logic [31:0] IO_BASE     = DEF_IO_BASE,
    parameter int          TIMEOUT_CYC = 64
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_sign,
    output logic        stall,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        MEM_RDEN2,
    output logic        MEM_WE2,
    output logic [31:0] MEM_ADDR2,
    output logic [31:0] MEM_DIN2,
    output logic [1:0]  MEM_SIZE,
    output logic        MEM_SIGN,
    input  logic [31:0] MEM_DOUT2,
    input  logic        memValid2,
    output logic [1:0]  dbg_state
);

    // Handshake: the pipeline holds req_valid and req_* until it sees
    // resp_valid; stall is high for exactly that span. The wrapper sees
    // strobes that stay high until the cycle it returns memValid2.

    state_t state, state_next;
    logic   mem_we_q;
    logic   req_legal, misaligned, is_io, expire;
    logic   issue, reject, done_ok, done_err;

`ifdef MISALIGN_TRAP_EN
    assign misaligned = is_misaligned(req_size, req_addr[1:0]);
`else
    assign misaligned = 1'b0;
`endif

    assign req_legal = (req_addr >= DMEM_BASE) && (req_size != 2'd3) && !misaligned;
    assign is_io     = (MEM_ADDR2 >= IO_BASE);

    dmem_watchdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_watchdog (
        .clk    (CLK),
        .rst    (RST),
        .clear  (state == S_RESP),
        .enable (state == S_WAIT),
        .expire (expire)
    );

    always_comb begin
        state_next = state;
        issue      = 1'b0;
        reject     = 1'b0;
        done_ok    = 1'b0;
        done_err   = 1'b0;
        case (state)
            S_IDLE: begin
                if (req_valid) begin
                    if (req_legal) begin
                        issue      = 1'b1;
                        state_next = S_WAIT;
                    end else begin
                        reject     = 1'b1;
                        state_next = S_RESP;
                    end
                end
            end
            S_WAIT: begin
                // IO never answers with memValid2; memValid2 beats a same-cycle timeout.
                if (is_io || memValid2) begin
                    done_ok    = 1'b1;
                    state_next = S_RESP;
                end else if (expire) begin
                    done_err   = 1'b1;
                    state_next = S_RESP;
                end
            end
            S_RESP:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= S_IDLE;
            mem_we_q   <= 1'b0;
            MEM_RDEN2  <= 1'b0;
            MEM_WE2    <= 1'b0;
            MEM_ADDR2  <= '0;
            MEM_DIN2   <= '0;
            MEM_SIZE   <= '0;
            MEM_SIGN   <= 1'b0;
            resp_rdata <= DEAD_BEEF;
            resp_err   <= 1'b0;
        end else begin
            state <= state_next;
            if (state == S_IDLE && req_valid) begin
                MEM_ADDR2 <= req_addr;
                MEM_DIN2  <= req_wdata;
                MEM_SIZE  <= req_size;
                MEM_SIGN  <= req_sign;
                mem_we_q  <= req_we;
            end
            if (issue) begin
                MEM_RDEN2 <= ~req_we;
                MEM_WE2   <= req_we;
            end else if (done_ok || done_err) begin
                MEM_RDEN2 <= 1'b0;
                MEM_WE2   <= 1'b0;
            end
            if (reject || done_err) begin
                resp_rdata <= DEAD_BEEF;
                resp_err   <= 1'b1;
            end else if (done_ok) begin
                resp_rdata <= mem_we_q ? 32'h0 : MEM_DOUT2;
                resp_err   <= 1'b0;
            end else if (state == S_RESP) begin
                resp_err <= 1'b0;
            end
        end
    end

    assign resp_valid = (state == S_RESP);
    assign stall      = req_valid & ~resp_valid;
    assign dbg_state  = state;

endmodule

// File: tb/tb_dmem_request_initiator.sv
// Directed bench for dmem_request_initiator with TIMEOUT_CYC=8.
// Honours MISALIGN_TRAP_EN for the misaligned word-load expectation.
module tb_dmem_request_initiator;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [1:0]  req_size = '0;
    logic        req_sign = 1'b0;
    logic        stall, resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic        MEM_RDEN2, MEM_WE2, MEM_SIGN;
    logic [31:0] MEM_ADDR2, MEM_DIN2;
    logic [1:0]  MEM_SIZE;
    logic [31:0] MEM_DOUT2 = '0;
    logic        memValid2 = 1'b0;
    logic [1:0]  dbg_state;

    int checks = 0;
    int errors = 0;

    dmem_request_initiator #(.TIMEOUT_CYC(8)) dut (
        .CLK(CLK), .RST(RST),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_size(req_size), .req_sign(req_sign),
        .stall(stall), .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .MEM_RDEN2(MEM_RDEN2), .MEM_WE2(MEM_WE2), .MEM_ADDR2(MEM_ADDR2), .MEM_DIN2(MEM_DIN2),
        .MEM_SIZE(MEM_SIZE), .MEM_SIGN(MEM_SIGN), .MEM_DOUT2(MEM_DOUT2), .memValid2(memValid2),
        .dbg_state(dbg_state)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drives one request, raises memValid2 in the mv_after-th strobe cycle
    // (0 = never), scrambles req_* once latched, and records what it saw.
    task automatic run_req(
        input  logic        we,
        input  logic [31:0] addr,
        input  logic [31:0] wdata,
        input  logic [1:0]  size,
        input  logic        sign,
        input  int          mv_after,
        input  logic [31:0] dout,
        output int          rd_cyc,
        output int          wr_cyc,
        output logic [31:0] rdata,
        output logic        err,
        output logic        stable,
        output logic        got_resp,
        output logic        stall_at_resp,
        output logic        one_pulse
    );
        @(negedge CLK);
        req_valid = 1'b1; req_we = we; req_addr = addr;
        req_wdata = wdata; req_size = size; req_sign = sign;
        MEM_DOUT2 = dout; memValid2 = 1'b0;
        rd_cyc = 0; wr_cyc = 0; rdata = '0; err = 1'b0;
        stable = 1'b1; got_resp = 1'b0; stall_at_resp = 1'b1; one_pulse = 1'b0;
        for (int i = 0; i < 40 && !got_resp; i++) begin
            @(negedge CLK);
            memValid2 = 1'b0;
            if (resp_valid) begin
                got_resp      = 1'b1;
                rdata         = resp_rdata;
                err           = resp_err;
                stall_at_resp = stall;
            end else begin
                if (MEM_RDEN2) rd_cyc++;
                if (MEM_WE2) wr_cyc++;
                if (MEM_RDEN2 || MEM_WE2) begin
                    if (MEM_ADDR2 !== addr || MEM_DIN2 !== wdata ||
                        MEM_SIZE !== size || MEM_SIGN !== sign) stable = 1'b0;
                end
                req_addr = ~addr; req_wdata = ~wdata; req_size = ~size;
                req_sign = ~sign; req_we = ~we;
                if (mv_after > 0 && (rd_cyc + wr_cyc) == mv_after) memValid2 = 1'b1;
            end
        end
        req_valid = 1'b0; memValid2 = 1'b0;
        @(negedge CLK);
        one_pulse = got_resp && !resp_valid;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        int          rd, wr;
        logic [31:0] rdata;
        logic        err, stable, got, st, pulse;
        logic        saw_resp;

        // Reset state
        @(negedge CLK);
        check("rst_stall", {31'b0, stall}, 32'd0);
        check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        check("rst_rdata", resp_rdata, 32'hDEAD_BEEF);
        check("rst_strobes", {30'b0, MEM_RDEN2, MEM_WE2}, 32'd0);
        check("rst_addr", MEM_ADDR2, 32'd0);
        check("rst_state", {30'b0, dbg_state}, 32'd0);
        RST = 1'b0;
        @(negedge CLK);

        // Stall is combinational on req_valid
        req_valid = 1'b1; req_addr = 32'h0000_6000; req_size = 2'd2; req_we = 1'b0;
        #1;
        check("stall_comb", {31'b0, stall}, 32'd1);
        req_valid = 1'b0;

        // Load word 0x6000, memValid2 in the 5th WAIT cycle
        run_req(1'b0, 32'h0000_6000, 32'h0, 2'd2, 1'b0, 5, 32'h1234_5678,
                rd, wr, rdata, err, stable, got, st, pulse);
        check("lw_got", {31'b0, got}, 32'd1);
        check("lw_rden_cyc", rd, 32'd5);
        check("lw_we_cyc", wr, 32'd0);
        check("lw_rdata", rdata, 32'h1234_5678);
        check("lw_err", {31'b0, err}, 32'd0);
        check("lw_stall", {31'b0, st}, 32'd0);
        check("lw_pulse", {31'b0, pulse}, 32'd1);
        check("lw_stable", {31'b0, stable}, 32'd1);

        // Store byte 0x6003, memValid2 in the 2nd WAIT cycle
        run_req(1'b1, 32'h0000_6003, 32'h0000_00AB, 2'd0, 1'b1, 2, 32'hFFFF_FFFF,
                rd, wr, rdata, err, stable, got, st, pulse);
        check("sb_we_cyc", wr, 32'd2);
        check("sb_rden_cyc", rd, 32'd0);
        check("sb_stable", {31'b0, stable}, 32'd1);
        check("sb_size", {30'b0, MEM_SIZE}, 32'd0);
        check("sb_din", MEM_DIN2, 32'h0000_00AB);
        check("sb_err", {31'b0, err}, 32'd0);
        check("sb_rdata", rdata, 32'd0);

        // IO load: exactly one WAIT cycle, no memValid2
        run_req(1'b0, 32'h0001_0004, 32'h0, 2'd2, 1'b0, 0, 32'h0000_CAFE,
                rd, wr, rdata, err, stable, got, st, pulse);
        check("io_rden_cyc", rd, 32'd1);
        check("io_rdata", rdata, 32'h0000_CAFE);
        check("io_err", {31'b0, err}, 32'd0);

        // Below DMEM_BASE: rejected without strobes
        run_req(1'b0, 32'h0000_0100, 32'h0, 2'd2, 1'b0, 0, 32'h1111_1111,
                rd, wr, rdata, err, stable, got, st, pulse);
        check("range_strobes", rd + wr, 32'd0);
        check("range_err", {31'b0, err}, 32'd1);
        check("range_rdata", rdata, 32'hDEAD_BEEF);

        // Illegal size 3
        run_req(1'b0, 32'h0000_6000, 32'h0, 2'd3, 1'b0, 0, 32'h1111_1111,
                rd, wr, rdata, err, stable, got, st, pulse);
        check("size3_strobes", rd + wr, 32'd0);
        check("size3_err", {31'b0, err}, 32'd1);

        // Watchdog: memValid2 never comes, abort after 8 WAIT cycles
        run_req(1'b0, 32'h0000_6010, 32'h0, 2'd2, 1'b0, 0, 32'h2222_2222,
                rd, wr, rdata, err, stable, got, st, pulse);
        check("to_got", {31'b0, got}, 32'd1);
        check("to_rden_cyc", rd, 32'd8);
        check("to_err", {31'b0, err}, 32'd1);
        check("to_rdata", rdata, 32'hDEAD_BEEF);

        // memValid2 on the timeout cycle wins
        run_req(1'b0, 32'h0000_6014, 32'h0, 2'd2, 1'b0, 8, 32'h3333_4444,
                rd, wr, rdata, err, stable, got, st, pulse);
        check("race_rden_cyc", rd, 32'd8);
        check("race_err", {31'b0, err}, 32'd0);
        check("race_rdata", rdata, 32'h3333_4444);

        // Misaligned word load 0x6002
        run_req(1'b0, 32'h0000_6002, 32'h0, 2'd2, 1'b0, 1, 32'h0000_55AA,
                rd, wr, rdata, err, stable, got, st, pulse);
`ifdef MISALIGN_TRAP_EN
        check("mis_strobes", rd + wr, 32'd0);
        check("mis_err", {31'b0, err}, 32'd1);
        check("mis_rdata", rdata, 32'hDEAD_BEEF);
`else
        check("mis_strobes", rd + wr, 32'd1);
        check("mis_err", {31'b0, err}, 32'd0);
        check("mis_rdata", rdata, 32'h0000_55AA);
`endif

        // memValid2 while idle is ignored
        @(negedge CLK);
        memValid2 = 1'b1;
        @(negedge CLK);
        memValid2 = 1'b0;
        check("idle_mv_resp", {31'b0, resp_valid}, 32'd0);
        check("idle_mv_state", {30'b0, dbg_state}, 32'd0);

        // Reset in the middle of WAIT
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0000_6020; req_size = 2'd2;
        repeat (3) @(negedge CLK);
        check("rstmid_rden_before", {31'b0, MEM_RDEN2}, 32'd1);
        RST = 1'b1;
        #1;
        check("rstmid_rden_after", {31'b0, MEM_RDEN2}, 32'd0);
        check("rstmid_state", {30'b0, dbg_state}, 32'd0);
        req_valid = 1'b0;
        saw_resp = 1'b0;
        repeat (3) begin
            @(negedge CLK);
            if (resp_valid) saw_resp = 1'b1;
        end
        RST = 1'b0;
        repeat (2) begin
            @(negedge CLK);
            if (resp_valid) saw_resp = 1'b1;
        end
        check("rstmid_no_resp", {31'b0, saw_resp}, 32'd0);

        // Normal traffic resumes after reset
        run_req(1'b0, 32'h0000_6040, 32'h0, 2'd1, 1'b0, 1, 32'h0000_BEEF,
                rd, wr, rdata, err, stable, got, st, pulse);
        check("post_rdata", rdata, 32'h0000_BEEF);
        check("post_err", {31'b0, err}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
